// File: rtl/lsq_pkg.sv
// Shared store-queue types and pointer helpers; no logic, no latency.
// Backpressure is owned by the queue itself (sq_full), not by anything here.
package lsq_pkg;

  localparam int SQ_DEPTH = 4;
  localparam int IDX_W    = $clog2(SQ_DEPTH);
  localparam int CNT_W    = $clog2(SQ_DEPTH + 1);

  typedef struct packed {
    logic [3:0] rob;
    logic       ready;
    logic       rsvd;
    logic       valid;
  } sq_ctrl_t;

  typedef struct packed {
    logic        isLS;
    logic [31:0] result;
    logic [5:0]  p_rd;
    logic [3:0]  rob;
    logic        RegDest;
  } ls_complete_t;

  function automatic logic [SQ_DEPTH-1:0] oh_rotl(input logic [SQ_DEPTH-1:0] v,
                                                  input int unsigned n);
    logic [2*SQ_DEPTH-1:0] dbl;
    dbl = {v, v} << (n % SQ_DEPTH);
    return dbl[2*SQ_DEPTH-1 -: SQ_DEPTH];
  endfunction

  function automatic logic [IDX_W-1:0] oh_to_idx(input logic [SQ_DEPTH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      if (v[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sq_data_mem.sv
// Private data memory: one synchronous write port, one combinational read port.
// Read data valid same cycle; writes land on the clock edge; never backpressures.
module sq_data_mem #(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lsq_store_queue.sv
// In-order store queue with load forwarding; completions registered one cycle after issue.
// Stores presented while sq_full are dropped and must be held upstream; loads always accepted.
module lsq_store_queue
  import lsq_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue,
  input  logic        mem_wen,
  input  logic        mem_ren,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [15:0] immed,
  input  logic [3:0]  rob_in,
  input  logic [5:0]  p_rd_in,
  input  logic        stall_hazard,
  input  logic        retire_ST,
  input  logic [3:0]  retire_rob,
  input  logic        recover,
  input  logic [3:0]  rec_rob,
  output logic        sq_full,
  output logic        isLS,
  output logic [31:0] load_result,
  output logic [5:0]  ls_p_rd,
  output logic [3:0]  ls_rob,
  output logic        ls_RegDest
);

  localparam int AW = $clog2(MEM_WORDS);

  sq_ctrl_t            control_queue [SQ_DEPTH];
  logic [31:0]         addr_queue    [SQ_DEPTH];
  logic [31:0]         data_queue    [SQ_DEPTH];
  logic [SQ_DEPTH-1:0] head, tail;
  logic [SQ_DEPTH-1:0] valid_vec, ready_vec;
  logic [IDX_W-1:0]    head_idx, tail_idx;
  logic [CNT_W-1:0]    n_ready;

  logic [31:0]  addr;
  logic         ld_go, st_go, drain;
  logic         mem_wen_out, mem_ren_out;
  logic         isFwd;
  logic [31:0]  fwd_data_int;
  logic [31:0]  mem_rdata;
  logic [31:0]  ld_data;
  ls_complete_t comp;
  logic         unused_rec;

  assign unused_rec = ^rec_rob;

  assign addr     = rs_data + {{16{immed[15]}}, immed};
  assign head_idx = oh_to_idx(head);
  assign tail_idx = oh_to_idx(tail);

  always_comb begin
    valid_vec = '0;
    ready_vec = '0;
    n_ready   = '0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      valid_vec[i] = control_queue[i].valid;
      ready_vec[i] = control_queue[i].valid & control_queue[i].ready;
      n_ready      = n_ready + CNT_W'(ready_vec[i]);
    end
  end

  assign sq_full = &valid_vec;

  // A recovery cycle discards whatever is issued alongside it.
  assign ld_go = issue & mem_ren & ~stall_hazard & ~recover;
  assign st_go = issue & mem_wen & ~stall_hazard & ~sq_full & ~recover;

  // Loads own the single memory port; a ready head waits behind them.
  assign drain       = ~ld_go & control_queue[head_idx].valid & control_queue[head_idx].ready;
  assign mem_wen_out = drain & ~rst;
  assign mem_ren_out = ld_go;

  // Walk oldest to youngest so the youngest matching store wins.
  always_comb begin
    logic [IDX_W-1:0] idx;
    isFwd        = 1'b0;
    fwd_data_int = '0;
    for (int k = SQ_DEPTH; k >= 1; k--) begin
      idx = tail_idx - IDX_W'(k);
      if (control_queue[idx].valid && addr_queue[idx] == addr) begin
        isFwd        = 1'b1;
        fwd_data_int = data_queue[idx];
      end
    end
  end

  sq_data_mem #(.MEM_WORDS(MEM_WORDS)) u_mem (
    .clk   (clk),
    .wen   (mem_wen_out),
    .waddr (addr_queue[head_idx][AW-1:0]),
    .wdata (data_queue[head_idx]),
    .raddr (addr[AW-1:0]),
    .rdata (mem_rdata)
  );

  assign ld_data = isFwd ? fwd_data_int : mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= SQ_DEPTH'(1);
      tail <= SQ_DEPTH'(1);
      for (int i = 0; i < SQ_DEPTH; i++) begin
        control_queue[i] <= '0;
        addr_queue[i]    <= '0;
        data_queue[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < SQ_DEPTH; i++) begin
        if (retire_ST && !recover && control_queue[i].valid &&
            control_queue[i].rob == retire_rob)
          control_queue[i].ready <= 1'b1;
      end
      if (drain) begin
        control_queue[head_idx].valid <= 1'b0;
        control_queue[head_idx].ready <= 1'b0;
        head <= oh_rotl(head, 1);
      end
      if (st_go) begin
        control_queue[tail_idx] <= '{rob: rob_in, ready: 1'b0, rsvd: 1'b0, valid: 1'b1};
        addr_queue[tail_idx]    <= addr;
        data_queue[tail_idx]    <= rt_data;
        tail <= oh_rotl(tail, 1);
      end
      // Retired stores survive recovery; the tail snaps to just past the last of them.
      if (recover) begin
        for (int i = 0; i < SQ_DEPTH; i++) begin
          if (!control_queue[i].ready) control_queue[i].valid <= 1'b0;
        end
        tail <= oh_rotl(head, int'(n_ready));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      comp <= '0;
    end else if (ld_go) begin
      comp <= '{isLS: 1'b1, result: ld_data, p_rd: p_rd_in, rob: rob_in, RegDest: 1'b1};
    end else if (st_go) begin
      comp.isLS    <= 1'b1;
      comp.result  <= '0;
      comp.rob     <= rob_in;
      comp.RegDest <= 1'b0;
    end else begin
      comp.isLS <= 1'b0;
    end
  end

  assign isLS        = comp.isLS;
  assign load_result = comp.result;
  assign ls_p_rd     = comp.p_rd;
  assign ls_rob      = comp.rob;
  assign ls_RegDest  = comp.RegDest;

endmodule

// File: tb/tb_lsq_store_queue.sv
// Directed bench for lsq_store_queue: fill, retire, drain, forward, recover, stall.
module tb_lsq_store_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue, mem_wen, mem_ren;
  logic [31:0] rs_data, rt_data;
  logic [15:0] immed;
  logic [3:0]  rob_in;
  logic [5:0]  p_rd_in;
  logic        stall_hazard, retire_ST, recover;
  logic [3:0]  retire_rob, rec_rob;
  logic        sq_full, isLS, ls_RegDest;
  logic [31:0] load_result;
  logic [5:0]  ls_p_rd;
  logic [3:0]  ls_rob;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lsq_store_queue dut (
    .clk(clk), .rst(rst), .issue(issue), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .rs_data(rs_data), .rt_data(rt_data), .immed(immed), .rob_in(rob_in),
    .p_rd_in(p_rd_in), .stall_hazard(stall_hazard), .retire_ST(retire_ST),
    .retire_rob(retire_rob), .recover(recover), .rec_rob(rec_rob),
    .sq_full(sq_full), .isLS(isLS), .load_result(load_result), .ls_p_rd(ls_p_rd),
    .ls_rob(ls_rob), .ls_RegDest(ls_RegDest)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    issue = 0; mem_wen = 0; mem_ren = 0; stall_hazard = 0;
    retire_ST = 0; recover = 0;
  endtask

  // Advance one edge, drop all strobes, and let combinational outputs settle.
  task automatic cyc();
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
  endtask

  task automatic store(input logic [3:0] rob, input logic [31:0] rs,
                       input logic [15:0] imm, input logic [31:0] d);
    issue = 1; mem_wen = 1; mem_ren = 0;
    rob_in = rob; rs_data = rs; immed = imm; rt_data = d;
  endtask

  task automatic load(input logic [3:0] rob, input logic [31:0] rs,
                      input logic [15:0] imm, input logic [5:0] prd);
    issue = 1; mem_wen = 0; mem_ren = 1;
    rob_in = rob; rs_data = rs; immed = imm; p_rd_in = prd;
  endtask

  task automatic retire(input logic [3:0] rob);
    retire_ST = 1; retire_rob = rob;
  endtask

  initial begin
    rst = 1; idle_inputs();
    rs_data = 0; rt_data = 0; immed = 0; rob_in = 0; p_rd_in = 0;
    retire_rob = 0; rec_rob = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1;
    chk("rst_head", 32'(dut.head), 32'h1);
    chk("rst_tail", 32'(dut.tail), 32'h1);
    chk("rst_full", 32'(sq_full), 0);
    chk("rst_isLS", 32'(isLS), 0);
    chk("rst_result", load_result, 0);
    chk("rst_rob", 32'(ls_rob), 0);
    chk("rst_regdest", 32'(ls_RegDest), 0);

    // Fill the queue; addresses built from mixed base/offset including a negative offset.
    store(4'd2, 32'd1, 16'd0, 32'h1234); cyc();
    chk("st1_isLS", 32'(isLS), 1);
    chk("st1_rob", 32'(ls_rob), 2);
    chk("st1_regdest", 32'(ls_RegDest), 0);
    chk("st1_result", load_result, 0);
    chk("st1_tail", 32'(dut.tail), 32'h2);
    store(4'd3, 32'd0, 16'd2, 32'h2345); cyc();
    store(4'd4, 32'd2, 16'd1, 32'h4567); cyc();
    store(4'd5, 32'd5, 16'hFFFF, 32'h5678); cyc();
    chk("fill_full", 32'(sq_full), 1);
    chk("fill_head", 32'(dut.head), 32'h1);
    chk("fill_tail", 32'(dut.tail), 32'h1);
    chk("sext_addr", dut.addr_queue[3], 32'd4);
    store(4'd6, 32'd9, 16'd0, 32'hDEAD); cyc();
    chk("drop_isLS", 32'(isLS), 0);
    chk("drop_rob_hold", 32'(ls_rob), 5);
    chk("drop_tail", 32'(dut.tail), 32'h1);
    chk("drop_full", 32'(sq_full), 1);

    retire(4'd2); #1;
    chk("ret2_no_wen", 32'(dut.mem_wen_out), 0);
    cyc();
    chk("ret2_ready0", 32'(dut.control_queue[0][2]), 1);
    chk("ret2_ready1", 32'(dut.control_queue[1][2]), 0);
    retire(4'd3); #1;
    chk("drain0_wen", 32'(dut.mem_wen_out), 1);
    cyc();
    chk("drain0_mem1", dut.u_mem.mem[1], 32'h1234);
    chk("drain0_head", 32'(dut.head), 32'h2);
    chk("drain0_full", 32'(sq_full), 0);
    chk("ret3_ready1", 32'(dut.control_queue[1][2]), 1);

    // Load beats a ready head for the memory port.
    load(4'd7, 32'd1, 16'd0, 6'd1); retire(4'd4); #1;
    chk("ld1_ren", 32'(dut.mem_ren_out), 1);
    chk("ld1_wen", 32'(dut.mem_wen_out), 0);
    chk("ld1_nofwd", 32'(dut.isFwd), 0);
    cyc();
    chk("ld1_isLS", 32'(isLS), 1);
    chk("ld1_result", load_result, 32'h1234);
    chk("ld1_prd", 32'(ls_p_rd), 1);
    chk("ld1_regdest", 32'(ls_RegDest), 1);
    chk("ld1_rob", 32'(ls_rob), 7);
    chk("ld1_head", 32'(dut.head), 32'h2);

    load(4'd8, 32'd3, 16'd0, 6'd2); retire(4'd5); #1;
    chk("ld3_fwd", 32'(dut.isFwd), 1);
    chk("ld3_fwd_data", dut.fwd_data_int, 32'h4567);
    cyc();
    chk("ld3_result", load_result, 32'h4567);
    chk("ld3_prd", 32'(ls_p_rd), 2);

    // Insert at tail while the head drains in the same edge.
    store(4'd9, 32'd3, 16'd0, 32'h9999); #1;
    chk("st9_drain_wen", 32'(dut.mem_wen_out), 1);
    cyc();
    chk("st9_head", 32'(dut.head), 32'h4);
    chk("st9_tail", 32'(dut.tail), 32'h2);
    chk("st9_mem2", dut.u_mem.mem[2], 32'h2345);
    chk("st9_rob", 32'(ls_rob), 9);
    chk("st9_full", 32'(sq_full), 0);

    // Two stores to addr 3 queued: the younger (wrapped into entry 0) must win.
    load(4'd10, 32'd3, 16'd0, 6'd3); #1;
    chk("young_fwd", 32'(dut.isFwd), 1);
    chk("young_fwd_data", dut.fwd_data_int, 32'h9999);
    cyc();
    chk("young_result", load_result, 32'h9999);

    // Recovery with a store and retire alongside: both ignored, ready entries keep going.
    recover = 1; rec_rob = 4'd9; store(4'd11, 32'd7, 16'd0, 32'hAAAA); retire(4'd9); #1;
    chk("rec_wen", 32'(dut.mem_wen_out), 1);
    cyc();
    chk("rec_isLS", 32'(isLS), 0);
    chk("rec_rob_hold", 32'(ls_rob), 10);
    chk("rec_head", 32'(dut.head), 32'h8);
    chk("rec_tail", 32'(dut.tail), 32'h1);
    chk("rec_full", 32'(sq_full), 0);
    chk("rec_kill0", 32'(dut.control_queue[0][0]), 0);
    chk("rec_keep3", 32'(dut.control_queue[3][0]), 1);
    chk("rec_mem3", dut.u_mem.mem[3], 32'h4567);

    #1;
    chk("tail_drain_wen", 32'(dut.mem_wen_out), 1);
    cyc();
    chk("tail_drain_mem4", dut.u_mem.mem[4], 32'h5678);
    chk("empty_head", 32'(dut.head), 32'h1);
    chk("empty_tail", 32'(dut.tail), 32'h1);
    chk("empty_valid3", 32'(dut.control_queue[3][0]), 0);

    load(4'd12, 32'd4, 16'd0, 6'd5); #1;
    chk("ld4_nofwd", 32'(dut.isFwd), 0);
    cyc();
    chk("ld4_result", load_result, 32'h5678);
    chk("ld4_rob", 32'(ls_rob), 12);
    chk("ld4_prd", 32'(ls_p_rd), 5);

    load(4'd13, 32'd3, 16'd0, 6'd6); stall_hazard = 1; #1;
    chk("stall_ld_ren", 32'(dut.mem_ren_out), 0);
    cyc();
    chk("stall_ld_isLS", 32'(isLS), 0);
    chk("stall_ld_hold", load_result, 32'h5678);

    store(4'd14, 32'd8, 16'd0, 32'hBEEF); stall_hazard = 1; cyc();
    chk("stall_st_tail", 32'(dut.tail), 32'h1);
    chk("stall_st_isLS", 32'(isLS), 0);

    load(4'd15, 32'd0, 16'd2, 6'd7); cyc();
    chk("ld2_mem_result", load_result, 32'h2345);
    chk("ld2_prd", 32'(ls_p_rd), 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
